// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB poller: UART register map, STATUS bit
// positions and the control FSM state encoding.
package uart_apb_pkg;

    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    localparam int STAT_TXRDY    = 0;
    localparam int STAT_RXRDY    = 1;
    localparam int STAT_PARITY   = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_FRAMING  = 4;

    typedef enum logic [2:0] {
        INIT_C1,
        INIT_C2,
        POLL,
        RD_RX,
        WR_TX
    } state_t;

endpackage

// File: rtl/uart_apb_xfer.sv
// Single-transfer APB master: a start request becomes one setup cycle followed
// by an access cycle that is held until the completer raises PREADY.
module uart_apb_xfer
    import uart_apb_pkg::*;
(
    input  logic       i_pclk,
    input  logic       i_presetn,
    input  logic       i_start,
    input  logic [4:0] i_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_write,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_slverr,
    output logic       o_psel,
    output logic       o_penable,
    output logic       o_pwrite,
    output logic [4:0] o_paddr,
    output logic [7:0] o_pwdata,
    input  logic [7:0] i_prdata,
    input  logic       i_pready,
    input  logic       i_pslverr
);

    logic       r_psel;
    logic       r_penable;
    logic       r_pwrite;
    logic [4:0] r_paddr;
    logic [7:0] r_pwdata;

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else if (r_psel && r_penable) begin
            if (i_pready) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end
        end else if (r_psel) begin
            r_penable <= 1'b1;
        end else if (i_start) begin
            r_psel   <= 1'b1;
            r_paddr  <= i_addr;
            r_pwdata <= i_wdata;
            r_pwrite <= i_write;
        end
    end

    assign o_done    = r_psel && r_penable && i_pready;
    assign o_rdata   = i_prdata;
    assign o_slverr  = i_pslverr;
    assign o_psel    = r_psel;
    assign o_penable = r_penable;
    assign o_pwrite  = r_pwrite;
    assign o_paddr   = r_paddr;
    assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/uart_apb_poller.sv
// Configures an APB UART once after reset, then polls STATUS and moves bytes
// between the UART and a pair of valid/ready streams, collecting sticky errors.
module uart_apb_poller
    import uart_apb_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter logic        BIT8       = 1'b1,
    parameter logic        PARITY_EN  = 1'b0,
    parameter logic        PARITY_ODD = 1'b0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_parity,
    output logic       err_framing,
    output logic       err_overflow,
    output logic       err_apb,
    input  logic       err_clr,
    output logic       cfg_done
);

    state_t     r_state, w_state_next, w_tgt;
    logic       w_start, w_write, w_done, w_slverr;
    logic [4:0] w_addr;
    logic [7:0] w_wdata, w_rdata;
    logic       r_busy, r_stat_vld;
    logic [1:0] r_status;
    logic       r_tx_full, r_rx_valid, r_cfg_done;
    logic [7:0] r_tx_buf, r_rx_data;
    logic       r_err_par, r_err_frm, r_err_ovf, r_err_apb;
    logic       w_stat_done, w_rx_done, w_tx_done, w_tx_load, w_rx_take;

    uart_apb_xfer u_xfer (
        .i_pclk    (PCLK),
        .i_presetn (PRESETN),
        .i_start   (w_start),
        .i_addr    (w_addr),
        .i_wdata   (w_wdata),
        .i_write   (w_write),
        .o_done    (w_done),
        .o_rdata   (w_rdata),
        .o_slverr  (w_slverr),
        .o_psel    (PSEL),
        .o_penable (PENABLE),
        .o_pwrite  (PWRITE),
        .o_paddr   (PADDR),
        .o_pwdata  (PWDATA),
        .i_prdata  (PRDATA),
        .i_pready  (PREADY),
        .i_pslverr (PSLVERR)
    );

    assign w_stat_done = w_done && (r_state == POLL);
    assign w_rx_done   = w_done && (r_state == RD_RX);
    assign w_tx_done   = w_done && (r_state == WR_TX);
    assign w_tx_load   = tx_valid && tx_ready;
    assign w_rx_take   = r_rx_valid && rx_ready;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) r_state <= INIT_C1;
        else          r_state <= w_state_next;
    end

    // A new transfer is issued on the cycle after each completion; in POLL that
    // cycle is also where the captured STATUS picks the next operation.
    always_comb begin
        w_tgt = r_state;
        if (r_state == POLL && r_stat_vld) begin
            if (r_status[STAT_RXRDY] && !r_rx_valid)    w_tgt = RD_RX;
            else if (r_status[STAT_TXRDY] && r_tx_full) w_tgt = WR_TX;
            else                                         w_tgt = POLL;
        end
        w_start      = !r_busy;
        w_state_next = r_state;
        if (w_start)     w_state_next = w_tgt;
        else if (w_done) w_state_next = (r_state == INIT_C1) ? INIT_C2 : POLL;
        w_addr  = ADDR_STATUS;
        w_wdata = '0;
        w_write = 1'b0;
        case (w_tgt)
            INIT_C1: begin
                w_addr  = ADDR_CTRL1;
                w_wdata = BAUD_VALUE[7:0];
                w_write = 1'b1;
            end
            INIT_C2: begin
                w_addr  = ADDR_CTRL2;
                w_wdata = {BAUD_VALUE[12:8], PARITY_ODD, PARITY_EN, BIT8};
                w_write = 1'b1;
            end
            RD_RX:   w_addr = ADDR_RXDATA;
            WR_TX: begin
                w_addr  = ADDR_TXDATA;
                w_wdata = r_tx_buf;
                w_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_busy     <= 1'b0;
            r_stat_vld <= 1'b0;
            r_status   <= '0;
            r_cfg_done <= 1'b0;
            r_tx_full  <= 1'b0;
            r_tx_buf   <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_err_par  <= 1'b0;
            r_err_frm  <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_apb  <= 1'b0;
        end else begin
            if (w_start)     r_busy <= 1'b1;
            else if (w_done) r_busy <= 1'b0;
            if (w_start)          r_stat_vld <= 1'b0;
            else if (w_stat_done) r_stat_vld <= 1'b1;
            if (w_stat_done) r_status <= w_rdata[1:0];
            if (w_done && r_state == INIT_C2) r_cfg_done <= 1'b1;
            // A rejected TX write keeps the byte so the next eligible poll retries it.
            if (w_tx_load) begin
                r_tx_full <= 1'b1;
                r_tx_buf  <= tx_data;
            end else if (w_tx_done && !w_slverr) begin
                r_tx_full <= 1'b0;
            end
            if (w_rx_done && !w_slverr) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_rdata;
            end else if (w_rx_take) begin
                r_rx_valid <= 1'b0;
            end
            r_err_par <= (w_stat_done && w_rdata[STAT_PARITY])   || (r_err_par && !err_clr);
            r_err_ovf <= (w_stat_done && w_rdata[STAT_OVERFLOW]) || (r_err_ovf && !err_clr);
            r_err_frm <= (w_stat_done && w_rdata[STAT_FRAMING])  || (r_err_frm && !err_clr);
            r_err_apb <= (w_done && w_slverr)                    || (r_err_apb && !err_clr);
        end
    end

    assign tx_ready     = r_cfg_done && !r_tx_full;
    assign rx_valid     = r_rx_valid;
    assign rx_data      = r_rx_data;
    assign cfg_done     = r_cfg_done;
    assign err_parity   = r_err_par;
    assign err_overflow = r_err_ovf;
    assign err_framing  = r_err_frm;
    assign err_apb      = r_err_apb;

endmodule

// File: tb/tb_uart_apb_poller.sv
// Directed bench for uart_apb_poller with a small APB UART completer model,
// a transfer log and a protocol monitor.
module tb_uart_apb_poller;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic [4:0] PADDR;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic       err_parity, err_framing, err_overflow, err_apb, err_clr, cfg_done;

    uart_apb_poller #(
        .BAUD_VALUE (13'h123),
        .BIT8       (1'b1),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b1)
    ) dut (
        .PCLK         (PCLK),
        .PRESETN      (PRESETN),
        .PADDR        (PADDR),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .err_parity   (err_parity),
        .err_framing  (err_framing),
        .err_overflow (err_overflow),
        .err_apb      (err_apb),
        .err_clr      (err_clr),
        .cfg_done     (cfg_done)
    );

    always #5 PCLK = ~PCLK;

    // Completer model
    logic [7:0] status_val = 8'h00;
    logic [7:0] rxdata_val = 8'h00;
    int         wait_target = 0;
    int         wait_cnt = 0;
    bit         slverr_tx = 1'b0;

    assign PREADY  = PSEL && PENABLE && (wait_cnt >= wait_target);
    assign PRDATA  = (PADDR == 5'h10) ? status_val : (PADDR == 5'h04) ? rxdata_val : 8'h00;
    assign PSLVERR = slverr_tx && PSEL && PENABLE && PWRITE && (PADDR == 5'h00);

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    // Transfer log and protocol monitor
    bit         log_wr[$];
    logic [4:0] log_addr[$];
    logic [7:0] log_data[$];
    int         log_len[$];
    bit         log_err[$];
    int n_stat = 0, n_rx = 0, n_tx = 0;
    int proto_viol = 0, gap = -1, gap_min = 1000, gap_max = 0, cur_len = 0;
    bit prev_psel = 0, prev_penable = 0, prev_ready = 0, prev_done = 0;
    logic [4:0] prev_paddr = '0;

    always @(negedge PCLK) begin
        if (!PRESETN) begin
            cur_len = 0; gap = -1;
            prev_psel = 0; prev_penable = 0; prev_ready = 0; prev_done = 0;
        end else begin
            if (PENABLE && !PSEL) proto_viol++;
            if (PSEL && PENABLE && !prev_psel) proto_viol++;
            if (PSEL && PENABLE && prev_penable && PADDR != prev_paddr) proto_viol++;
            if (prev_psel && prev_penable && !prev_ready && !(PSEL && PENABLE)) proto_viol++;
            if (prev_done && PSEL) proto_viol++;
            if (gap >= 0) begin
                if (PSEL) begin
                    if (gap < gap_min) gap_min = gap;
                    if (gap > gap_max) gap_max = gap;
                    gap = -1;
                end else begin
                    gap++;
                end
            end
            if (PSEL && PENABLE) cur_len++;
            if (PSEL && PENABLE && PREADY) begin
                log_wr.push_back(PWRITE);
                log_addr.push_back(PADDR);
                log_data.push_back(PWRITE ? PWDATA : PRDATA);
                log_len.push_back(cur_len);
                log_err.push_back(PSLVERR);
                if (!PWRITE && PADDR == 5'h10) n_stat++;
                if (!PWRITE && PADDR == 5'h04) n_rx++;
                if (PWRITE && PADDR == 5'h00)  n_tx++;
                $display("[%0t] APB %s addr=0x%02h data=0x%02h access=%0d slverr=%0b", $time,
                         PWRITE ? "WR" : "RD", PADDR, PWRITE ? PWDATA : PRDATA, cur_len, PSLVERR);
                cur_len = 0;
                gap = 0;
            end
            prev_psel = PSEL; prev_penable = PENABLE; prev_ready = PREADY;
            prev_done = PSEL && PENABLE && PREADY; prev_paddr = PADDR;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    // sel: 0 = log entries, 1 = STATUS reads, 2 = RXDATA reads, 3 = TXDATA writes
    task automatic wait_until(input int sel, input int target, input int budget, input string tag);
        int v;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (sel)
                0:       v = log_addr.size();
                1:       v = n_stat;
                2:       v = n_rx;
                default: v = n_tx;
            endcase
            if (v >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, " reached"}, 32'(ok), 1);
    endtask

    function automatic logic [13:0] ent(input int i);
        return {log_wr[i], log_addr[i], log_data[i]};
    endfunction

    initial begin
        int s, t, r, k, ri, wi, i1, i2;
        bit bad;
        tx_valid = 0; tx_data = 0; rx_ready = 0; err_clr = 0;
        repeat (3) tick();

        check("rst PSEL", PSEL, 0);
        check("rst PENABLE", PENABLE, 0);
        check("rst PWRITE/PADDR/PWDATA", {PWRITE, PADDR, PWDATA}, 0);
        check("rst rx_valid/rx_data", {rx_valid, rx_data}, 0);
        check("rst tx_ready/cfg_done", {tx_ready, cfg_done}, 0);
        check("rst err flags", {err_parity, err_overflow, err_framing, err_apb}, 0);

        // Init writes
        PRESETN = 1;
        tick();
        check("pre-init tx_ready", tx_ready, 0);
        check("pre-init cfg_done", cfg_done, 0);
        wait_until(0, 2, 50, "init writes");
        check("CTRL1 write", ent(0), {1'b1, 5'h08, 8'h23});
        check("CTRL2 write", ent(1), {1'b1, 5'h0C, 8'h0F});
        tick();
        check("cfg_done after init", cfg_done, 1);
        check("tx_ready after init", tx_ready, 1);

        // TX byte held until TXRDY
        tx_data = 8'h5A; tx_valid = 1;
        tick();
        tx_valid = 0;
        check("tx_ready after load", tx_ready, 0);
        s = n_stat; t = n_tx;
        wait_until(1, s + 10, 200, "10 polls");
        check("no TX write while TXRDY=0", n_tx, t);
        status_val = 8'h01;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (n_tx > t) break;
            if (tx_ready) bad = 1;
        end
        check("TX write seen", n_tx, t + 1);
        check("tx_ready low until write", bad, 0);
        check("TX write 0x00:0x5A", ent(log_addr.size() - 1), {1'b1, 5'h00, 8'h5A});
        tick();
        check("tx_ready after write", tx_ready, 1);
        status_val = 8'h00;
        repeat (20) tick();
        check("exactly one TX write", n_tx, t + 1);

        // RX byte held until consumed
        r = n_rx; rxdata_val = 8'hA5; status_val = 8'h02;
        wait_until(2, r + 1, 100, "RX read");
        tick();
        check("rx_valid set", rx_valid, 1);
        check("rx_data A5", rx_data, 8'hA5);
        bad = 0;
        repeat (20) begin
            tick();
            if (!rx_valid || rx_data !== 8'hA5) bad = 1;
        end
        check("rx held 20 cycles", bad, 0);
        check("no RX reread while held", n_rx, r + 1);
        status_val = 8'h00; rx_ready = 1;
        tick();
        rx_ready = 0;
        check("rx_valid cleared", rx_valid, 0);
        repeat (10) tick();
        check("no extra RX read", n_rx, r + 1);

        // RX and TX both eligible, 3 wait states
        wait_target = 3;
        tick();
        check("tx_ready before dual", tx_ready, 1);
        tx_data = 8'hC3; tx_valid = 1;
        tick();
        tx_valid = 0; rxdata_val = 8'h77;
        k = log_addr.size(); t = n_tx;
        status_val = 8'h03;
        wait_until(3, t + 1, 200, "dual TX write");
        ri = -1; wi = -1;
        for (int i = k; i < log_addr.size(); i++) begin
            if (ri < 0 && !log_wr[i] && log_addr[i] == 5'h04) ri = i;
            if (wi < 0 && log_wr[i] && log_addr[i] == 5'h00) wi = i;
        end
        check("RX read before TX write", 32'(ri >= 0 && wi > ri), 1);
        check("access held 4 cycles", (ri >= 0) ? log_len[ri] : 0, 4);
        check("dual TX data", (wi >= 0) ? log_data[wi] : 8'h00, 8'hC3);
        tick();
        check("dual rx_data", {rx_valid, rx_data}, {1'b1, 8'h77});
        status_val = 8'h00; wait_target = 0; rx_ready = 1;
        tick();
        rx_ready = 0;
        repeat (5) tick();

        // STATUS error bits and clear
        status_val = 8'h1C; s = n_stat;
        wait_until(1, s + 1, 100, "error STATUS read");
        tick();
        status_val = 8'h00;
        check("error flags set", {err_parity, err_overflow, err_framing, err_apb}, 4'b1110);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("error flags cleared", {err_parity, err_overflow, err_framing, err_apb}, 4'b0000);

        // Set wins over a simultaneous clear
        err_clr = 1; status_val = 8'h04; s = n_stat;
        wait_until(1, s + 1, 100, "parity STATUS read");
        tick();
        check("set beats clear", {err_parity, err_overflow}, 2'b10);
        status_val = 8'h00;
        repeat (3) tick();
        check("held clear", err_parity, 0);
        err_clr = 0;

        // PSLVERR on TX write: flag and retry
        check("tx_ready before slverr", tx_ready, 1);
        slverr_tx = 1; tx_data = 8'h96; tx_valid = 1;
        tick();
        tx_valid = 0; t = n_tx; status_val = 8'h01;
        wait_until(3, t + 1, 100, "errored TX write");
        i1 = log_addr.size() - 1;
        tick();
        slverr_tx = 0;
        check("err_apb set", err_apb, 1);
        check("TX buffer kept", tx_ready, 0);
        check("errored write", {log_err[i1], log_data[i1]}, {1'b1, 8'h96});
        wait_until(3, t + 2, 100, "retried TX write");
        i2 = log_addr.size() - 1;
        check("retried write", {log_err[i2], log_data[i2]}, {1'b0, 8'h96});
        tick();
        check("tx_ready after retry", tx_ready, 1);
        status_val = 8'h00;

        // Reset during an access cycle
        wait_target = 5;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (PENABLE) break;
        end
        check("access phase reached", PENABLE, 1);
        PRESETN = 0;
        #1;
        check("abort PSEL/PENABLE", {PSEL, PENABLE}, 2'b00);
        check("abort cfg_done", cfg_done, 0);
        wait_target = 0;
        repeat (2) tick();
        k = log_addr.size();
        PRESETN = 1;
        wait_until(0, k + 1, 50, "reinit write");
        check("CTRL1 reissued", ent(k), {1'b1, 5'h08, 8'h23});
        repeat (10) tick();

        check("APB protocol violations", proto_viol, 0);
        check("min idle between transfers", gap_min, 1);
        check("max idle between transfers", gap_max, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
